// File: rtl/viterbi_ber_checker.sv
// rtl/viterbi_ber_checker.sv - receive-side BER checker for the Viterbi decode chain
//
// Buffers transmitted info bits in a reference FIFO, pops one per decoded bit,
// compares, acquires lock, counts compares/errors in LOCK and flags loss of lock.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clear      synchronous soft clear, same effect as rst
//   tx_valid   transmitted info bit present
//   tx_bit     transmitted info bit
//   dec_valid  decoded bit present
//   dec_bit    decoded bit
//   state      0 IDLE, 1 ACQ, 2 LOCK, 3 LOST
//   err_o      one-cycle pulse per mismatching compare
//   bit_ct     compares counted in LOCK (saturating)
//   err_ct     mismatches counted in LOCK (saturating)
//   max_burst  longest mismatch run in LOCK (saturating)
//   ovf        sticky FIFO overflow
//   udf        sticky FIFO underflow
//
// Optional feature macro: BER_CHK_BURST_EN (burst tracking; max_burst tied 0 when undefined)

module viterbi_ber_checker #(
    parameter int DEPTH    = 64,
    parameter int LOCK_RUN = 16,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        tx_valid,
    input  logic        tx_bit,
    input  logic        dec_valid,
    input  logic        dec_bit,
    output logic [1:0]  state,
    output logic        err_o,
    output logic [31:0] bit_ct,
    output logic [31:0] err_ct,
    output logic [15:0] max_burst,
    output logic        ovf,
    output logic        udf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACQ = 2'd1, S_LOCK = 2'd2, S_LOST = 2'd3} state_t;

    state_t cur_st, nxt_st;

    logic             srst;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fill;
    logic             empty, full, push_ok, pop_ok, mis;

    logic [7:0]       run;
    logic [8:0]       run_nxt;
    logic [15:0]      win_cnt, win_err;
    logic [16:0]      win_err_nxt;
    logic             win_last;
    logic             acq_cmp, lock_cmp, run_hit, loss_hit;

    assign srst  = rst | clear;
    assign empty = (fill == '0);
    assign full  = (fill == (AW+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // alongside a pop. An empty FIFO never bypasses a simultaneous push.
    assign pop_ok  = dec_valid & ~empty;
    assign push_ok = tx_valid & (~full | pop_ok);
    assign mis     = pop_ok & (mem[rd_ptr] ^ dec_bit);

    assign run_nxt  = {1'b0, run} + 9'd1;
    assign win_last = (win_cnt == 16'(WIN - 1));
    // The compare that completes a window seeds the next window's error count.
    assign win_err_nxt = win_last ? {16'd0, mis} : ({1'b0, win_err} + {16'd0, mis});

    always_ff @(posedge clk) begin
        if (push_ok && !srst) begin
            mem[wr_ptr] <= tx_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (srst) cur_st <= S_IDLE;
        else      cur_st <= nxt_st;
    end

    // FSM: next-state logic
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            S_IDLE: if (push_ok)           nxt_st = S_ACQ;
            S_ACQ:  if (acq_cmp && run_hit)  nxt_st = S_LOCK;
            S_LOCK: if (lock_cmp && loss_hit) nxt_st = S_LOST;
            default: nxt_st = cur_st;
        endcase
    end

    // FSM: per-state datapath enables
    always_comb begin
        acq_cmp  = pop_ok && (cur_st == S_ACQ);
        lock_cmp = pop_ok && (cur_st == S_LOCK);
        run_hit  = !mis && (run_nxt == 9'(LOCK_RUN));
        loss_hit = (win_err_nxt == 17'(LOSS_THR + 1));
    end

    assign state = cur_st;

    always_ff @(posedge clk) begin
        if (srst) begin
            err_o   <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            run     <= '0;
            bit_ct  <= '0;
            err_ct  <= '0;
            win_cnt <= '0;
            win_err <= '0;
        end else begin
            err_o <= mis;
            ovf   <= ovf | (tx_valid & ~push_ok);
            udf   <= udf | (dec_valid & empty);
            if (acq_cmp) begin
                run <= mis ? 8'd0 : run_nxt[7:0];
            end
            if (lock_cmp) begin
                bit_ct  <= bit_ct + {31'd0, ~&bit_ct};
                err_ct  <= err_ct + {31'd0, mis & ~&err_ct};
                win_cnt <= win_last ? 16'd0 : win_cnt + 16'd1;
                win_err <= win_err_nxt[15:0];
            end
        end
    end

`ifdef BER_CHK_BURST_EN
    logic [15:0] cur_burst, burst_nxt;

    assign burst_nxt = mis ? (cur_burst + {15'd0, ~&cur_burst}) : 16'd0;

    always_ff @(posedge clk) begin
        if (srst) begin
            cur_burst <= '0;
            max_burst <= '0;
        end else if (lock_cmp) begin
            cur_burst <= burst_nxt;
            if (burst_nxt > max_burst) max_burst <= burst_nxt;
        end
    end
`else
    assign max_burst = 16'd0;
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb/tb_viterbi_ber_checker.sv - self-checking bench for viterbi_ber_checker
module tb_viterbi_ber_checker;
    localparam int DEPTH    = 64;
    localparam int LOCK_RUN = 16;
    localparam int WIN      = 64;
    localparam int LOSS_THR = 8;
`ifdef BER_CHK_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clear, tx_valid, tx_bit, dec_valid, dec_bit;
    logic [1:0]  state;
    logic        err_o, ovf, udf;
    logic [31:0] bit_ct, err_ct;
    logic [15:0] max_burst;

    always #5 clk = ~clk;

    viterbi_ber_checker #(
        .DEPTH(DEPTH), .LOCK_RUN(LOCK_RUN), .WIN(WIN), .LOSS_THR(LOSS_THR)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .tx_valid(tx_valid), .tx_bit(tx_bit),
        .dec_valid(dec_valid), .dec_bit(dec_bit),
        .state(state), .err_o(err_o), .bit_ct(bit_ct), .err_ct(err_ct),
        .max_burst(max_burst), .ovf(ovf), .udf(udf)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue for the FIFO, plain integers for the counters.
    // Windows are identified arithmetically by lock compare index.
    bit     m_q[$];
    int     m_state, m_run, m_win_errs, m_burst, m_max;
    longint m_bit_ct, m_err_ct, m_lock_n, m_win_id;
    bit     m_ovf, m_udf, m_erro;

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_state = 0; m_run = 0; m_win_errs = 0; m_burst = 0; m_max = 0;
        m_bit_ct = 0; m_err_ct = 0; m_lock_n = 0; m_win_id = 0;
        m_ovf = 0; m_udf = 0; m_erro = 0;
    endtask

    task automatic model_step(input bit tv, input bit tb, input bit dv, input bit db, input bit clr);
        bit     pop, push, p, mis;
        longint win;
        if (clr) begin
            model_reset();
            return;
        end
        pop  = dv && (m_q.size() > 0);
        push = tv && ((m_q.size() < DEPTH) || pop);
        if (dv && !pop) m_udf = 1;
        if (tv && !push) m_ovf = 1;
        m_erro = 0;
        if (pop) begin
            p = m_q.pop_front();
            mis = p ^ db;
            m_erro = mis;
            if (m_state == 1) begin
                m_run = mis ? 0 : m_run + 1;
                if (m_run == LOCK_RUN) m_state = 2;
            end else if (m_state == 2) begin
                m_bit_ct = sat(m_bit_ct + 1, 64'hFFFF_FFFF);
                if (mis) m_err_ct = sat(m_err_ct + 1, 64'hFFFF_FFFF);
                win = (m_lock_n + 1) / WIN;
                if (win != m_win_id) begin
                    m_win_id = win;
                    m_win_errs = 0;
                end
                m_win_errs += int'(mis);
                m_lock_n++;
                m_burst = mis ? int'(sat(m_burst + 1, 65535)) : 0;
                if (m_burst > m_max) m_max = m_burst;
                if (m_win_errs > LOSS_THR) m_state = 3;
            end
        end
        if (push) begin
            m_q.push_back(tb);
            if (m_state == 0) m_state = 1;
        end
    endtask

    task automatic check_all();
        check("state",     64'(state),     64'(m_state));
        check("err_o",     64'(err_o),     64'(m_erro));
        check("bit_ct",    64'(bit_ct),    64'(m_bit_ct));
        check("err_ct",    64'(err_ct),    64'(m_err_ct));
        check("max_burst", 64'(max_burst), BURST_EN ? 64'(m_max) : 64'd0);
        check("ovf",       64'(ovf),       64'(m_ovf));
        check("udf",       64'(udf),       64'(m_udf));
    endtask

    task automatic step(input bit tv, input bit tb, input bit dv, input bit db, input bit clr, input bit rs);
        tx_valid = tv; tx_bit = tb; dec_valid = dv; dec_bit = db; clear = clr; rst = rs;
        model_step(tv, tb, dv, db, clr | rs);
        @(posedge clk);
        #1;
        check_all();
        if (err_o) pulses++;
    endtask

    // Decoded bit is the expected reference bit, optionally flipped.
    task automatic cmp_step(input bit tv, input bit dv, input bit flip, input bit clr, input bit rs);
        bit front;
        front = (m_q.size() > 0) ? m_q[0] : bit'($urandom);
        step(tv, bit'($urandom), dv, front ^ flip, clr, rs);
    endtask

    bit pushed[$];

    initial begin
        rst = 1; clear = 0; tx_valid = 0; tx_bit = 0; dec_valid = 0; dec_bit = 0;
        model_reset();

        // Reset values
        step(0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 0, 1);
        check("rst_state", 64'(state), 0);
        check("rst_bit_ct", 64'(bit_ct), 0);
        check("rst_ovf_udf", 64'({ovf, udf, err_o}), 0);

        // Error-free stream, decoded bits lagging 20 cycles
        pulses = 0;
        for (int c = 0; c < 320; c++) cmp_step(c < 300, c >= 20, 0, 0, 0);
        check("ef_state", 64'(state), 2);
        check("ef_bit_ct", 64'(bit_ct), 284);
        check("ef_err_ct", 64'(err_ct), 0);
        check("ef_pulses", 64'(pulses), 0);

        // Sparse errors: every 100th lock compare flipped over 1000 compares
        step(0, 0, 0, 0, 1, 0);
        pulses = 0;
        cmp_step(1, 0, 0, 0, 0);
        for (int c = 0; c < 3000 && m_lock_n < 1000; c++)
            cmp_step(1, 1, (m_state == 2) && ((m_lock_n + 1) % 100 == 0), 0, 0);
        check("sp_err_ct", 64'(err_ct), 10);
        check("sp_pulses", 64'(pulses), 10);
        check("sp_state", 64'(state), 2);
        check("sp_max_burst", 64'(max_burst), BURST_EN ? 1 : 0);

        // Loss by a 9-long burst inside one window
        step(0, 0, 0, 0, 1, 0);
        cmp_step(1, 0, 0, 0, 0);
        for (int c = 0; c < 150; c++)
            cmp_step(1, 1, ((m_state == 2) && m_lock_n >= 40 && m_lock_n < 49) ||
                           ((m_state == 3) && bit'($urandom)), 0, 0);
        check("bu_state", 64'(state), 3);
        check("bu_err_ct", 64'(err_ct), 9);
        check("bu_bit_ct", 64'(bit_ct), 49);
        check("bu_max_burst", 64'(max_burst), BURST_EN ? 9 : 0);

        // Overflow: 65 pushes, then 64 pops against the first 64 pushed bits
        step(0, 0, 0, 0, 1, 0);
        pushed.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            bit b;
            b = bit'($urandom);
            pushed.push_back(b);
            step(1, b, 0, 0, 0, 0);
        end
        check("ov_flag", 64'(ovf), 1);
        pulses = 0;
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, pushed[i], 0, 0);
        check("ov_order_pulses", 64'(pulses), 0);
        check("ov_udf", 64'(udf), 0);
        step(0, 0, 1, 0, 0, 0);
        check("ov_drained_udf", 64'(udf), 1);

        // Underflow including a simultaneous first push
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 1, 0, 0);
        check("ud_flag", 64'(udf), 1);
        check("ud_err_o", 64'(err_o), 0);
        check("ud_state", 64'(state), 1);
        check("ud_bit_ct", 64'(bit_ct), 0);

        // Clear, then reset, in the middle of LOCK
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0, 1, 0);
            cmp_step(1, 0, 0, 0, 0);
            for (int c = 0; c < 500 && m_bit_ct < 50; c++) cmp_step(1, 1, 0, 0, 0);
            check("cl_pre_bit_ct", 64'(bit_ct), 50);
            step(1, 1, 1, 1, k == 0, k == 1);
            check("cl_state", 64'(state), 0);
            check("cl_outs", 64'({bit_ct, err_ct}), 0);
            check("cl_flags", 64'({err_o, ovf, udf, max_burst}), 0);
            step(0, 0, 1, 0, 0, 0);
            check("cl_empty_udf", 64'(udf), 1);
        end

        // Randomized traffic with varying load, error rate and occasional clears
        for (int r = 0; r < 4; r++) begin
            int ptx, pdx, perr;
            ptx  = 40 + 20 * r;
            pdx  = 90 - 15 * r;
            perr = (r == 0) ? 0 : (r == 1) ? 20 : (r == 2) ? 120 : 350;
            step(0, 0, 0, 0, 0, 1);
            for (int c = 0; c < 2000; c++)
                cmp_step($urandom_range(0, 99) < ptx, $urandom_range(0, 99) < pdx,
                         $urandom_range(0, 999) < perr, $urandom_range(0, 599) == 0,
                         $urandom_range(0, 1999) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Receive-side bit-error-rate checker for the convolutional encode / channel / Viterbi decode chain. It stores every transmitted information bit in a reference FIFO, pops one entry per decoded bit, and compares the two. It acquires lock, counts bits and errors, and flags loss of lock. It sits beside the decoder output in the tx/rx test harness and replaces ad hoc `$display` error tallies with synthesizable counters.

## Interface
Parameters:
- `DEPTH`, 64: reference FIFO depth in bits; power of 2, 4..1024.
- `LOCK_RUN`, 16: consecutive matches required to declare lock; 1..255.
- `WIN`, 64: loss-detection window length, in compares; 2..65535.
- `LOSS_THR`, 8: error limit inside one window; exceeding it means loss; 1..WIN-1.

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clear`  in  1: synchronous soft clear; same effect as `rst`.
- `tx_valid`  in  1: a transmitted info bit is present (encoder input enable).
- `tx_bit`  in  1: the transmitted info bit.
- `dec_valid`  in  1: a decoded bit is present.
- `dec_bit`  in  1: the decoded bit.
- `state`  out  2: 0 IDLE, 1 ACQ, 2 LOCK, 3 LOST.
- `err_o`  out  1: one-cycle pulse on a mismatching compare, in any state.
- `bit_ct`  out  32: compares counted in LOCK; saturating.
- `err_ct`  out  32: mismatches counted in LOCK; saturating.
- `max_burst`  out  16: longest run of consecutive mismatches in LOCK; saturating.
- `ovf`  out  1: sticky FIFO overflow flag.
- `udf`  out  1: sticky FIFO underflow flag.

## Operation
- **FIFO push:** push `tx_bit` when `tx_valid` is high and the FIFO is not full.
  - `tx_valid` while full and not popping: the bit is dropped, `ovf` is set, and existing contents are kept.
  - Push and pop in the same cycle while full: both succeed.
- **FIFO pop:** pop and compare when `dec_valid` is high and the FIFO is not empty.
  - `dec_valid` while empty: `udf` is set and there is no compare. There is no bypass, even with a simultaneous push.
- **Compare:** mismatch = popped bit XOR `dec_bit`.
- **IDLE:** go to ACQ on the first successful push.
- **ACQ:**
  - Run counter increments on a match and resets to 0 on a mismatch.
  - When the run reaches `LOCK_RUN`, go to LOCK on that edge. That compare is not counted.
  - `bit_ct` and `err_ct` stay 0.
- **LOCK:**
  - Each compare: `bit_ct` += 1; on a mismatch, `err_ct` += 1 and the window error count += 1.
  - The window compare count wraps after `WIN` compares. On the wrap, the window error count returns to 0, or to 1 if the wrapping compare is itself a mismatch.
  - When the window error count reaches `LOSS_THR`+1, go to LOST on that edge. That compare is counted.
- **LOST:** terminal. Counters and `max_burst` freeze, and `err_o` keeps pulsing. Leave only via `rst` or `clear`.
- **Saturation:** all counters saturate at all-ones and never wrap.
- **Clear and reset:** `rst` or `clear`, including mid-operation, empties the FIFO, zeroes all counters and flags, and enters IDLE. Any `tx_valid` or `dec_valid` in that same cycle is ignored.

## Timing
- Reset values: `state`=0, `err_o`=0, `bit_ct`=0, `err_ct`=0, `max_burst`=0, `ovf`=0, `udf`=0.
- All outputs are registered.
- Compare latency is 1: for `dec_valid` at edge k, `err_o`, the counters and `state` update at edge k+1.
- Push-to-pop latency is 1: a bit pushed at edge k can be popped at edge k+1 or later.
- Flags become visible one cycle after the offending request.

## Configuration
- **`BER_CHK_BURST_EN` defined:**
  - A 16-bit current-burst counter increments on a LOCK mismatch and resets to 0 on a LOCK match.
  - `max_burst` takes the maximum of itself and the new burst value on each update.
- **`BER_CHK_BURST_EN` undefined:** the burst logic is removed and `max_burst` is tied to 0. All other behaviour is identical.

## Test plan
- **Error-free stream:** defaults; 300 `tx_valid` bits; decoded stream = same bits delayed 20 cycles -> LOCK after compare 16; final `bit_ct`=284, `err_ct`=0, `err_o` never high.
- **Sparse errors:** after LOCK, flip every 100th decoded bit over 1000 bits -> `err_ct`=10, exactly 10 `err_o` pulses, `state` stays LOCK, `max_burst`=1 with the macro.
- **Loss by burst:** after LOCK, 9 consecutive flipped bits inside one window -> LOST at the 9th compare edge, `err_ct`=9; later compares leave the counters unchanged; `max_burst`=9 with the macro, 0 without.
- **Overflow:** 65 pushes with no pops -> `ovf`=1; the next 64 pops return the first 64 pushed bits in order.
- **Underflow:** `dec_valid` with the FIFO empty, including the same cycle as the first push -> `udf`=1, no `err_o`, counters 0, `state` = ACQ.
- **Clear mid-LOCK:** `bit_ct`=50 when `clear` is asserted with `tx_valid` and `dec_valid` high -> next cycle all outputs are 0, `state`=IDLE and the FIFO is empty; repeat with `rst` for the same result.
